// File: rtl/mult_share_sched.sv
// Round-robin scheduler sharing one iterative shift-add multiplier
// among NREQ requesters; returns a 2*WIDTH product tagged with the id.
//
// Ports:
//   clk, rst   rising-edge clock, synchronous active-high reset
//   req        per-requester request level
//   a_in/b_in  packed operands, requester k uses [k*WIDTH +: WIDTH]
//   gnt        one-hot accept pulse (first CALC cycle)
//   busy       engine occupied (CALC or DONE)
//   out_valid  one-cycle result pulse
//   out_id     requester id of the current result (held)
//   out_prod   unsigned product a*b (held until the next result)
module mult_share_sched #(
    parameter int WIDTH = 8,
    parameter int NREQ  = 4,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] a_in,
    input  logic [NREQ*WIDTH-1:0] b_in,
    output logic [NREQ-1:0]       gnt,
    output logic                  busy,
    output logic                  out_valid,
    output logic [IDW-1:0]        out_id,
    output logic [2*WIDTH-1:0]    out_prod
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [IDW-1:0]     id_q, id_d;
    logic [IDW-1:0]     ptr_q, ptr_d;
    logic [NREQ-1:0]    gnt_q, gnt_d;
    logic               out_valid_q, out_valid_d;
    logic [IDW-1:0]     out_id_q, out_id_d;
    logic [2*WIDTH-1:0] out_prod_q, out_prod_d;

    logic [IDW-1:0]     win;
    logic               found;
    int                 idx;

    logic [WIDTH:0]     step_sum;
    logic [WIDTH-1:0]   step_acc;
    logic [WIDTH-1:0]   step_mplier;

    // Search starts one past the last winner so every requester
    // gets a turn before any one is served twice.
    always_comb begin
        win   = '0;
        found = 1'b0;
        idx   = 0;
        for (int i = 1; i <= NREQ; i++) begin
            idx = (int'(ptr_q) + i) % NREQ;
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = IDW'(idx);
            end
        end
    end

    // One add/shift step; the carry out of the add shifts into acc.
    always_comb begin
        step_sum    = {1'b0, acc_q}
                    + (mplier_q[0] ? {1'b0, mcand_q} : '0);
        step_acc    = step_sum[WIDTH:1];
        step_mplier = {step_sum[0], mplier_q[WIDTH-1:1]};
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        acc_d       = acc_q;
        id_d        = id_q;
        ptr_d       = ptr_q;
        gnt_d       = '0;
        out_valid_d = 1'b0;
        out_id_d    = out_id_q;
        out_prod_d  = out_prod_q;

        unique case (state_q)
            IDLE: begin
                if (|req) begin
                    mcand_d  = a_in[int'(win)*WIDTH +: WIDTH];
                    mplier_d = b_in[int'(win)*WIDTH +: WIDTH];
                    acc_d    = '0;
                    cnt_d    = '0;
                    id_d     = win;
                    ptr_d    = win;
                    gnt_d[win] = 1'b1;
                    state_d  = CALC;
                end
            end
            CALC: begin
                acc_d    = step_acc;
                mplier_d = step_mplier;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d     = DONE;
                    out_prod_d  = {step_acc, step_mplier};
                    out_id_d    = id_q;
                    out_valid_d = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            acc_q       <= '0;
            id_q        <= '0;
            ptr_q       <= IDW'(NREQ - 1);
            gnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_id_q    <= '0;
            out_prod_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            acc_q       <= acc_d;
            id_q        <= id_d;
            ptr_q       <= ptr_d;
            gnt_q       <= gnt_d;
            out_valid_q <= out_valid_d;
            out_id_q    <= out_id_d;
            out_prod_q  <= out_prod_d;
        end
    end

    assign gnt       = gnt_q;
    assign busy      = (state_q != IDLE);
    assign out_valid = out_valid_q;
    assign out_id    = out_id_q;
    assign out_prod  = out_prod_q;

endmodule

// File: tb/tb_mult_share_sched.sv
// Self-checking bench for mult_share_sched: a transaction-level
// model compared every cycle plus directed literal checks.
module tb_mult_share_sched;

    localparam int W   = 8;
    localparam int N   = 4;
    localparam int IDW = 2;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req;
    logic [N*W-1:0] a_in;
    logic [N*W-1:0] b_in;
    logic [N-1:0]   gnt;
    logic           busy;
    logic           out_valid;
    logic [IDW-1:0] out_id;
    logic [2*W-1:0] out_prod;

    mult_share_sched #(.WIDTH(W), .NREQ(N)) dut (
        .clk(clk), .rst(rst), .req(req), .a_in(a_in), .b_in(b_in),
        .gnt(gnt), .busy(busy), .out_valid(out_valid),
        .out_id(out_id), .out_prod(out_prod)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Model: an op occupies the engine for W+1 cycles after its grant
    // edge; the result appears in the last of those cycles.
    int             m_left = 0;
    int             m_ptr  = N - 1;
    logic [N-1:0]   m_gnt  = '0;
    logic           m_val  = 1'b0;
    int             m_id   = 0;
    int             m_prod = 0;
    int             c_id   = 0;
    int             c_prod = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_left = 0; m_ptr = N - 1; m_gnt = '0; m_val = 1'b0;
            m_id = 0; m_prod = 0;
        end else begin
            m_gnt = '0;
            m_val = 1'b0;
            if (m_left == 0) begin
                if (|req) begin
                    int w;
                    w = -1;
                    for (int i = 1; i <= N; i++)
                        if (w < 0 && req[(m_ptr + i) % N]) w = (m_ptr + i) % N;
                    m_gnt[w] = 1'b1;
                    c_id   = w;
                    c_prod = int'(a_in[w*W +: W]) * int'(b_in[w*W +: W]);
                    m_ptr  = w;
                    m_left = W + 1;
                end
            end else begin
                m_left--;
                if (m_left == 1) begin
                    m_val = 1'b1; m_id = c_id; m_prod = c_prod;
                end
            end
        end
    end

    bit cmp_en = 0;
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("gnt", 32'(gnt), 32'(m_gnt));
            chk("busy", 32'(busy), 32'(m_left > 0));
            chk("out_valid", 32'(out_valid), 32'(m_val));
            chk("out_id", 32'(out_id), 32'(m_id));
            chk("out_prod", 32'(out_prod), 32'(m_prod));
        end
    end

    // Observation logs filled from DUT outputs, checked against literals.
    int g_log[$];
    int v_prod[$];
    int v_id[$];
    int busy_cnt = 0;

    always @(negedge clk) begin
        for (int i = 0; i < N; i++) if (gnt[i]) g_log.push_back(i);
        if (out_valid) begin
            v_prod.push_back(int'(out_prod));
            v_id.push_back(int'(out_id));
        end
        if (busy) busy_cnt++;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_logs();
        g_log.delete(); v_prod.delete(); v_id.delete(); busy_cnt = 0;
    endtask

    task automatic set_ops(input int k, input int a, input int b);
        a_in[k*W +: W] = W'(a);
        b_in[k*W +: W] = W'(b);
    endtask

    // Requester k runs one op; cyc counts cycles with the gnt cycle as 1.
    task automatic run_op(input int k, input int a, input int b,
                          output int cyc);
        int budget;
        set_ops(k, a, b);
        req = '0;
        req[k] = 1'b1;
        cyc = 0;
        budget = 40;
        while (v_prod.size() == 0 && budget > 0) begin
            tick();
            budget--;
            if (cyc > 0) cyc++;
            else if (g_log.size() > 0) begin
                cyc = 1;
                req = '0;
            end
        end
        if (budget == 0) chk("op_timeout", 32'(1), 32'(0));
        req = '0;
    endtask

    task automatic wait_idle();
        int budget;
        budget = 30;
        while (busy && budget > 0) begin
            tick();
            budget--;
        end
        tick();
    endtask

    initial begin
        int cyc;
        int budget;
        int ops;
        rst = 1'b1; req = '0; a_in = '0; b_in = '0;
        @(posedge clk);
        cmp_en = 1;
        repeat (2) tick();
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_prod", 32'(out_prod), 32'(0));
        chk("rst_gnt", 32'(gnt), 32'(0));
        rst = 1'b0;

        // 1: 13*11
        clear_logs();
        run_op(0, 13, 11, cyc);
        chk("t1_lat", 32'(cyc), 32'(9));
        chk("t1_prod", 32'(v_prod[0]), 32'h008F);
        chk("t1_id", 32'(v_id[0]), 32'(0));
        wait_idle();

        // 2: 255*255 on requester 2
        clear_logs();
        run_op(2, 255, 255, cyc);
        chk("t2_prod", 32'(v_prod[0]), 32'hFE01);
        chk("t2_lo", 32'(v_prod[0] & 8'hFF), 32'h01);
        chk("t2_id", 32'(v_id[0]), 32'(2));
        wait_idle();

        // 3: zero operand, then 1*200; busy spans 9 cycles each
        clear_logs();
        run_op(1, 0, 200, cyc);
        wait_idle();
        chk("t3_prod0", 32'(v_prod[0]), 32'h0000);
        chk("t3_busy0", 32'(busy_cnt), 32'(9));
        clear_logs();
        run_op(3, 1, 200, cyc);
        wait_idle();
        chk("t3_prod1", 32'(v_prod[0]), 32'h00C8);
        chk("t3_busy1", 32'(busy_cnt), 32'(9));

        // 4: all requesting -> rotation, then lone req[1]
        // Pointer is 3 after test 3, so req[0] is next.
        clear_logs();
        for (int k = 0; k < N; k++) set_ops(k, k + 3, 2 * k + 5);
        req = '1;
        budget = 100;
        while (g_log.size() < 5 && budget > 0) begin
            tick();
            budget--;
        end
        req = '0;
        wait_idle();
        chk("t4_ngnt", 32'(g_log.size()), 32'(5));
        if (g_log.size() >= 5) begin
            chk("t4_g0", 32'(g_log[0]), 32'(0));
            chk("t4_g1", 32'(g_log[1]), 32'(1));
            chk("t4_g2", 32'(g_log[2]), 32'(2));
            chk("t4_g3", 32'(g_log[3]), 32'(3));
            chk("t4_g4", 32'(g_log[4]), 32'(0));
        end
        clear_logs();
        run_op(1, 6, 7, cyc);
        chk("t4_lone", 32'(g_log[0]), 32'(1));
        chk("t4_lone_p", 32'(v_prod[0]), 32'(42));
        wait_idle();

        // 5: reset 4 cycles into CALC
        clear_logs();
        set_ops(2, 7, 9);
        req = 4'b0100;
        budget = 10;
        while (g_log.size() == 0 && budget > 0) begin
            tick();
            budget--;
        end
        req = '0;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t5_busy", 32'(busy), 32'(0));
        chk("t5_prod", 32'(out_prod), 32'(0));
        chk("t5_id", 32'(out_id), 32'(0));
        chk("t5_val", 32'(out_valid), 32'(0));
        repeat (12) tick();
        chk("t5_noval", 32'(v_prod.size()), 32'(0));
        clear_logs();
        set_ops(0, 3, 4);
        req = 4'b0101;
        tick();
        req = '0;
        chk("t5_first", 32'(g_log.size() > 0 ? g_log[0] : -1), 32'(0));
        wait_idle();

        // 6a: requests while busy are held off until after out_valid
        clear_logs();
        set_ops(0, 5, 5);
        for (int k = 1; k < N; k++) set_ops(k, 10 + k, 20 + k);
        req = 4'b0001;
        tick();
        req = 4'b1111;
        budget = 20;
        while (v_prod.size() == 0 && budget > 0) begin
            tick();
            budget--;
        end
        chk("t6_hold", 32'(g_log.size()), 32'(1));
        tick();
        tick();
        req = '0;
        chk("t6_next", 32'(g_log.size() > 1 ? g_log[1] : -1), 32'(1));
        wait_idle();

        // 6b: random traffic against the model
        clear_logs();
        ops = 0;
        budget = 20000;
        while (ops < 1000 && budget > 0) begin
            if (g_log.size() > 0 || $urandom_range(0, 7) == 0) begin
                ops += g_log.size();
                g_log.delete();
                for (int k = 0; k < N; k++)
                    set_ops(k, $urandom_range(0, 255), $urandom_range(0, 255));
                req = N'($urandom_range(0, 15));
            end
            tick();
            budget--;
        end
        req = '0;
        wait_idle();
        chk("t6_ops", 32'(ops >= 1000), 32'(1));

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
